// File: rtl/uart_rx_frame_filter_if.sv
// Bus between the UART receive stage and the frame filter.
// The receive-stage side drives the strobes and payload; the filter side drives the filtered result.
interface uart_rx_frame_filter_if #(
  parameter int NBIT = 10
) ();
  logic            t128ms_tick;
  logic            frame_valid;
  logic            frame_error;
  logic [NBIT-1:0] frame_data;
  logic            err_clr;
  logic [NBIT-1:0] data_out;
  logic            data_update;
  logic            link_up;
  logic [7:0]      err_cnt;

  modport master (
    output t128ms_tick, frame_valid, frame_error, frame_data, err_clr,
    input  data_out, data_update, link_up, err_cnt
  );

  modport slave (
    input  t128ms_tick, frame_valid, frame_error, frame_data, err_clr,
    output data_out, data_update, link_up, err_cnt
  );
endinterface

// File: rtl/uart_rx_frame_filter.sv
// Debounces received UART frames: the output follows only after MATCH_NUM identical
// frames, and falls back to a default value when no frame arrives for LOSS_TICKS ticks.
module uart_rx_frame_filter #(
  parameter int   NBIT       = 10,
  parameter int   MATCH_NUM  = 3,
  parameter int   LOSS_TICKS = 8,
  parameter logic DEF_OUTPUT = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  uart_rx_frame_filter_if.slave      bus
);

  localparam logic [3:0]      MN      = 4'(MATCH_NUM);
  localparam logic [3:0]      LT      = 4'(LOSS_TICKS);
  localparam logic [NBIT-1:0] DEF_VEC = {NBIT{DEF_OUTPUT}};

  typedef enum logic [1:0] {S_DOWN, S_ACQ, S_LOCK} state_t;

  state_t          r_state, w_state_nxt;
  logic [NBIT-1:0] r_cand, w_cand_nxt;
  logic [3:0]      r_mcnt, w_mcnt_nxt;
  logic [3:0]      r_tcnt, w_tcnt_nxt;
  logic [NBIT-1:0] r_data_out, w_data_out_nxt;
  logic            r_data_update, w_data_update_nxt;
  logic [7:0]      r_err_cnt, w_err_cnt_nxt;

  logic w_accept, w_same, w_match, w_expire;

  assign w_accept = bus.frame_valid & ~bus.frame_error;
  assign w_same   = (r_mcnt != 4'd0) && (bus.frame_data == r_cand);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_DOWN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cand_nxt        = r_cand;
    w_mcnt_nxt        = r_mcnt;
    w_tcnt_nxt        = r_tcnt;
    w_data_out_nxt    = r_data_out;
    w_data_update_nxt = 1'b0;
    w_err_cnt_nxt     = r_err_cnt;

    if (bus.frame_error) begin
      w_mcnt_nxt = 4'd0;
    end else if (w_accept) begin
      if (w_same) begin
        w_mcnt_nxt = (r_mcnt >= MN) ? MN : r_mcnt + 4'd1;
      end else begin
        w_cand_nxt = bus.frame_data;
        w_mcnt_nxt = 4'd1;
      end
    end

    if (w_accept) begin
      w_tcnt_nxt = 4'd0;
    end else if (bus.t128ms_tick && (r_tcnt < LT)) begin
      w_tcnt_nxt = r_tcnt + 4'd1;
    end

    // An accepted frame zeroes the timer, so a match always wins over a coincident expiry.
    w_match  = w_accept && (w_mcnt_nxt == MN);
    w_expire = !w_accept && bus.t128ms_tick && (r_tcnt < LT) &&
               ((r_tcnt + 4'd1) == LT) && (r_state != S_DOWN);

    if (w_match) begin
      w_state_nxt       = S_LOCK;
      w_data_out_nxt    = w_cand_nxt;
      w_data_update_nxt = (w_cand_nxt != r_data_out);
    end else if (w_expire) begin
      w_state_nxt       = S_DOWN;
      w_mcnt_nxt        = 4'd0;
      w_data_out_nxt    = DEF_VEC;
      w_data_update_nxt = (r_data_out != DEF_VEC);
    end else if (w_accept && (r_state == S_DOWN)) begin
      w_state_nxt = S_ACQ;
    end

    if (bus.frame_error) begin
      if (bus.err_clr) begin
        w_err_cnt_nxt = 8'd1;
      end else if (r_err_cnt != 8'hFF) begin
        w_err_cnt_nxt = r_err_cnt + 8'd1;
      end
    end else if (bus.err_clr) begin
      w_err_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand        <= '0;
      r_mcnt        <= '0;
      r_tcnt        <= '0;
      r_data_out    <= DEF_VEC;
      r_data_update <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_cand        <= w_cand_nxt;
      r_mcnt        <= w_mcnt_nxt;
      r_tcnt        <= w_tcnt_nxt;
      r_data_out    <= w_data_out_nxt;
      r_data_update <= w_data_update_nxt;
      r_err_cnt     <= w_err_cnt_nxt;
    end
  end

  assign bus.data_out    = r_data_out;
  assign bus.data_update = r_data_update;
  assign bus.link_up     = (r_state == S_LOCK);
  assign bus.err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_uart_rx_frame_filter.sv
// Scoreboard bench: stimulus queues expected output updates, a monitor checks each data_update.
module tb_uart_rx_frame_filter;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;

  always #5 clk = ~clk;

  uart_rx_frame_filter_if #(.NBIT(10)) ifa ();
  uart_rx_frame_filter_if #(.NBIT(10)) ifb ();

  uart_rx_frame_filter #(.NBIT(10), .MATCH_NUM(3), .LOSS_TICKS(8), .DEF_OUTPUT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
  );

  uart_rx_frame_filter #(.NBIT(10), .MATCH_NUM(1), .LOSS_TICKS(8), .DEF_OUTPUT(1'b1)) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(ifb.slave)
  );

  typedef struct {
    logic [9:0] d;
    logic       l;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic e, input logic t, input logic c,
                       input logic [9:0] d);
    ifa.frame_valid = v;
    ifa.frame_error = e;
    ifa.t128ms_tick = t;
    ifa.err_clr     = c;
    ifa.frame_data  = d;
    @(posedge clk);
    #1;
    ifa.frame_valid = 1'b0;
    ifa.frame_error = 1'b0;
    ifa.t128ms_tick = 1'b0;
    ifa.err_clr     = 1'b0;
    ifa.frame_data  = '0;
  endtask

  task automatic frame(input logic [9:0] d);
    drive(1'b1, 1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 10'h000);
  endtask

  task automatic expect_upd(input logic [9:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    q.push_back(e);
  endtask

  // Monitor: every data_update pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && ifa.data_update) begin
      if (q.size() == 0) begin
        check("unexpected_update", 32'(ifa.data_out), 32'h0000_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("upd_data_out", 32'(ifa.data_out), 32'(e.d));
        check("upd_link_up", 32'(ifa.link_up), 32'(e.l));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rst2_n = 1'b0;
    ifa.frame_valid = 1'b0; ifa.frame_error = 1'b0; ifa.t128ms_tick = 1'b0;
    ifa.err_clr = 1'b0; ifa.frame_data = '0;
    ifb.frame_valid = 1'b0; ifb.frame_error = 1'b0; ifb.t128ms_tick = 1'b0;
    ifb.err_clr = 1'b0; ifb.frame_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", 32'(ifa.data_out), 32'h000);
    check("rst_link_up", 32'(ifa.link_up), 32'd0);
    check("rst_err_cnt", 32'(ifa.err_cnt), 32'd0);
    check("rst_data_update", 32'(ifa.data_update), 32'd0);
    check("rst2_data_out", 32'(ifb.data_out), 32'h3FF);
    rst_n = 1'b1;
    rst2_n = 1'b1;

    // Acquire 0x155
    frame(10'h155);
    check("acq_link_up", 32'(ifa.link_up), 32'd0);
    frame(10'h155);
    expect_upd(10'h155, 1'b1);
    frame(10'h155);
    check("lock_link_up", 32'(ifa.link_up), 32'd1);
    check("lock_data_out", 32'(ifa.data_out), 32'h155);

    // Re-match inside LOCK
    frame(10'h0AA);
    frame(10'h155);
    frame(10'h0AA);
    frame(10'h0AA);
    check("rematch_hold", 32'(ifa.data_out), 32'h155);
    check("rematch_link", 32'(ifa.link_up), 32'd1);
    expect_upd(10'h0AA, 1'b1);
    frame(10'h0AA);
    check("rematch_new", 32'(ifa.data_out), 32'h0AA);

    // Loss timer: a frame on the 8th tick keeps the link
    repeat (7) tick();
    check("seven_ticks_link", 32'(ifa.link_up), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 10'h0AA);
    check("tick_frame_link", 32'(ifa.link_up), 32'd1);
    repeat (7) tick();
    check("pre_expiry_link", 32'(ifa.link_up), 32'd1);
    expect_upd(10'h000, 1'b0);
    tick();
    check("expiry_link", 32'(ifa.link_up), 32'd0);
    check("expiry_data_out", 32'(ifa.data_out), 32'h000);
    repeat (3) tick();
    check("down_data_out", 32'(ifa.data_out), 32'h000);

    // Error counter saturation and clear
    repeat (255) drive(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
    check("err_255", 32'(ifa.err_cnt), 32'd255);
    repeat (45) drive(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
    check("err_sat", 32'(ifa.err_cnt), 32'd255);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 10'h000);
    check("err_clr_with_err", 32'(ifa.err_cnt), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
    check("err_clr", 32'(ifa.err_cnt), 32'd0);

    // Errors (including valid+error) restart matching
    frame(10'h123);
    check("acq2_link", 32'(ifa.link_up), 32'd0);
    frame(10'h123);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 10'h123);
    check("valid_err_cnt", 32'(ifa.err_cnt), 32'd1);
    frame(10'h123);
    frame(10'h123);
    check("restart_no_lock", 32'(ifa.link_up), 32'd0);
    expect_upd(10'h123, 1'b1);
    frame(10'h123);
    check("restart_lock", 32'(ifa.link_up), 32'd1);

    // Asynchronous reset during a partial re-match in LOCK
    frame(10'h050);
    frame(10'h050);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data", 32'(ifa.data_out), 32'h000);
    check("async_rst_link", 32'(ifa.link_up), 32'd0);
    check("async_rst_err", 32'(ifa.err_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    frame(10'h050);
    check("post_rst_acq", 32'(ifa.link_up), 32'd0);
    frame(10'h050);
    expect_upd(10'h050, 1'b1);
    frame(10'h050);
    check("post_rst_lock", 32'(ifa.data_out), 32'h050);

    // MATCH_NUM=1, DEF_OUTPUT=1 instance
    ifb.frame_valid = 1'b1;
    ifb.frame_data  = 10'h001;
    @(posedge clk);
    #1;
    ifb.frame_valid = 1'b0;
    ifb.frame_data  = '0;
    check("m1_link", 32'(ifb.link_up), 32'd1);
    check("m1_data_out", 32'(ifb.data_out), 32'h001);
    check("m1_update", 32'(ifb.data_update), 32'd1);
    #2;
    rst2_n = 1'b0;
    #1;
    check("m1_rst_data", 32'(ifb.data_out), 32'h3FF);
    check("m1_rst_link", 32'(ifb.link_up), 32'd0);
    @(posedge clk);
    #1;
    rst2_n = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_filter.md
UART_RX_FRAME_FILTER -- requirements
Module: uart_rx_frame_filter

Interface
REQ-001 Parameter NBIT, default 10: width of the received payload.
REQ-002 Parameter MATCH_NUM, default 3: consecutive identical frames required before the output updates; legal range 1..15.
REQ-003 Parameter LOSS_TICKS, default 8: number of t128ms_tick pulses with no valid frame before the link is declared lost; legal range 1..15.
REQ-004 Parameter DEF_OUTPUT, default 1'b0: bit value replicated across data_out while the link is down.
REQ-005 clk  input  1  single system clock; all logic is on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 t128ms_tick  input  1  one-cycle timebase pulse, period 128 ms.
REQ-008 frame_valid  input  1  one-cycle strobe from the UART receive stage: frame_data holds a newly accepted frame.
REQ-009 frame_error  input  1  one-cycle strobe from the UART receive stage: a frame failed its start/stop marker check.
REQ-010 frame_data  input  NBIT  received payload; sampled only when frame_valid=1.
REQ-011 err_clr  input  1  one-cycle strobe that clears err_cnt.
REQ-012 data_out  output  NBIT  filtered, stable payload.
REQ-013 data_update  output  1  one-cycle pulse in the first cycle data_out holds a new value.
REQ-014 link_up  output  1  high while the filter is in LOCK.
REQ-015 err_cnt  output  8  saturating count of frame_error strobes.

Function
REQ-016 State machine states: DOWN, ACQ, LOCK; link_up SHALL be 1 only in LOCK.
REQ-017 Internal candidate register cand (NBIT) and match counter mcnt (4 bit) SHALL track consecutive identical frames.
REQ-018 On frame_valid with frame_error=0: if mcnt!=0 and frame_data==cand, mcnt SHALL increment, saturating at MATCH_NUM; otherwise cand<=frame_data and mcnt<=1.
REQ-019 frame_valid and frame_error asserted in the same cycle SHALL be treated as frame_error only; the frame is discarded.
REQ-020 frame_error SHALL set mcnt<=0 and increment err_cnt, saturating at 255; it SHALL NOT clear the loss timer.
REQ-021 err_clr SHALL set err_cnt to 0; err_clr together with frame_error in the same cycle SHALL give err_cnt=1.
REQ-022 DOWN->ACQ: on the first accepted frame_valid.
REQ-023 ACQ->LOCK: on the edge where mcnt becomes MATCH_NUM. With MATCH_NUM=1, this is the first accepted frame, and DOWN->LOCK happens directly.
REQ-024 When mcnt becomes MATCH_NUM in any state, data_out<=cand on that edge (one-cycle latency from the qualifying frame_valid). data_update SHALL pulse in the following cycle only if the new value differs from the previous data_out.
REQ-025 In LOCK, a differing frame SHALL restart matching; data_out SHALL hold until MATCH_NUM identical frames arrive, and link_up SHALL stay 1.
REQ-026 Loss timer tcnt (4 bit) behaviour:
- increments on each t128ms_tick;
- clears to 0 on every accepted frame_valid;
- saturates at LOSS_TICKS;
- accepted frame_valid and t128ms_tick in the same cycle SHALL give tcnt=0.
REQ-027 On the edge where tcnt becomes LOSS_TICKS in ACQ or LOCK, the block SHALL:
- go to DOWN;
- set mcnt<=0;
- set data_out<={NBIT{DEF_OUTPUT}};
- pulse data_update if data_out changed.
REQ-028 In DOWN, timer expiry SHALL have no further effect; data_out SHALL remain at the default value.
REQ-029 A timer expiry and a match completion on the same edge SHALL be resolved in favour of the frame: the accepted frame clears tcnt, so no expiry occurs.

Reset
REQ-030 While rst_n=0, the block SHALL hold the following values:
- state=DOWN;
- data_out={NBIT{DEF_OUTPUT}};
- data_update=0, link_up=0, err_cnt=0;
- cand=0, mcnt=0, tcnt=0.
REQ-031 Reset asserted mid-acquisition or in LOCK SHALL take effect immediately and discard any partial match.
REQ-032 After rst_n deasserts, the first accepted frame_valid SHALL be evaluated normally on the next clock edge.

Verification
REQ-033 Defaults, frames 0x155, 0x155, 0x155 -> link_up=1 and data_out=0x155 one cycle after the third strobe; single data_update pulse.
REQ-034 In LOCK with 0x155, frames 0x0AA, 0x155, 0x0AA, 0x0AA, 0x0AA -> data_out=0x155 until the final strobe, then 0x0AA; link_up stays 1 throughout.
REQ-035 In LOCK, 8 ticks with no frame -> link_up=0, data_out=0x000, data_update pulse; a frame_valid coincident with the 8th tick -> stays in LOCK.
REQ-036 300 frame_error strobes -> err_cnt=255; err_clr coincident with a frame_error -> err_cnt=1; an error between matching frames restarts the count at 1.
REQ-037 MATCH_NUM=1, DEF_OUTPUT=1: reset -> data_out=0x3FF; one frame 0x001 -> LOCK and data_out=0x001 next cycle; rst_n pulse mid-LOCK -> data_out=0x3FF immediately.
